// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scanner.
package mux_scan_pkg;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam int              NUM_CH  = 4;
  localparam int              SEL_W   = 2;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;
endpackage

// File: rtl/mux4_1.sv
// Combinational 4:1 mux driven by the scanner's channel select.
module mux4_1 (
  input  logic [1:0] sel_in,
  input  logic [3:0] a_in,
  output logic       y_out
);
  assign y_out = a_in[sel_in];
endmodule

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: flags the last cycle of each channel's hold time.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic tick_out
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick   = (r_cnt == LAST_CNT);
  assign tick_out = w_tick;

  // Count dwell cycles, wrapping to zero on the sample edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (clear_in) begin
      r_cnt <= '0;
    end else if (enable_in) begin
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel scanner: steps the mux select, samples each channel after a dwell
// period and publishes the assembled 4-bit word with valid/change strobes.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             mode_in,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel_out,
  output logic [NUM_CH-1:0] sample_out,
  output logic             valid_out,
  output logic             change_out,
  output logic             busy_out
);
  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [NUM_CH-2:0]   r_shadow;
  logic [NUM_CH-1:0]   r_sample;
  logic                r_valid;
  logic                r_change;
  logic                r_busy;
  logic                w_tick;
  logic                w_cnt_clear;
  logic                w_cnt_en;
  logic [NUM_CH-1:0]   w_new_sample;

  // Counter runs only while scanning; an abort restarts it from zero
  assign w_cnt_clear  = (r_state != SCAN) || stop_in;
  assign w_cnt_en     = (r_state == SCAN);
  assign w_new_sample = {y_in, r_shadow};

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clear_in  (w_cnt_clear),
    .enable_in (w_cnt_en),
    .tick_out  (w_tick)
  );

  // Scan FSM with channel, shadow and result registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_shadow <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_change <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in && !stop_in) begin
            r_state  <= SCAN;
            r_sel    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end
        end
        SCAN: begin
          // Abort takes priority over a coincident end-of-scan sample
          if (stop_in) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
          end else if (w_tick) begin
            if (r_sel == LAST_CH) begin
              r_sample <= w_new_sample;
              r_valid  <= 1'b1;
              r_change <= (w_new_sample != r_sample);
              r_shadow <= '0;
              r_sel    <= '0;
              if (mode_in) begin
                r_state <= SCAN;
                r_busy  <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_shadow[r_sel] <= y_in;
              r_sel           <= r_sel + 2'd1;
            end
          end else begin
            r_sel <= r_sel;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_sel    <= '0;
          r_shadow <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign sel_out    = r_sel;
  assign sample_out = r_sample;
  assign valid_out  = r_valid;
  assign change_out = r_change;
  assign busy_out   = r_busy;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: scanner + mux4_1 at DWELL=4 and DWELL=1.
module tb_mux_scan_ctrl;
  logic       clk;
  logic       rst_n;
  logic       start, stop, mode;
  logic [3:0] a;
  logic [1:0] sel;
  logic       y;
  logic [3:0] sample;
  logic       valid, change, busy;

  logic       start1, stop1, mode1;
  logic [3:0] a1;
  logic [1:0] sel1;
  logic       y1;
  logic [3:0] sample1;
  logic       valid1, change1, busy1;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt;

  mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop),
    .mode_in(mode), .y_in(y), .sel_out(sel), .sample_out(sample),
    .valid_out(valid), .change_out(change), .busy_out(busy)
  );
  mux4_1 u_mux (.sel_in(sel), .a_in(a), .y_out(y));

  mux_scan_ctrl #(.DWELL(1), .CNT_W(2)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .stop_in(stop1),
    .mode_in(mode1), .y_in(y1), .sel_out(sel1), .sample_out(sample1),
    .valid_out(valid1), .change_out(change1), .busy_out(busy1)
  );
  mux4_1 u_mux1 (.sel_in(sel1), .a_in(a1), .y_out(y1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Counts negedges until the chosen DUT shows valid; limit+1 means timeout
  task automatic wait_v(input bit which, input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which ? valid1 : valid) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; a = 4'b1010;
    start1 = 1'b0; stop1 = 1'b0; mode1 = 1'b0; a1 = 4'b1111;
    #12;
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_sample", {28'd0, sample}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_change", {31'd0, change}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan of 1010
    pulse_start();
    chk("s_busy0", {31'd0, busy}, 32'd1);
    chk("s_sel0", {30'd0, sel}, 32'd0);
    repeat (4) @(negedge clk);
    chk("s_sel1", {30'd0, sel}, 32'd1);
    repeat (4) @(negedge clk);
    chk("s_sel2", {30'd0, sel}, 32'd2);
    repeat (4) @(negedge clk);
    chk("s_sel3", {30'd0, sel}, 32'd3);
    repeat (3) @(negedge clk);
    chk("s_valid_early", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("s_valid", {31'd0, valid}, 32'd1);
    chk("s_sample", {28'd0, sample}, 32'h0000_000a);
    chk("s_change", {31'd0, change}, 32'd1);
    chk("s_busy_end", {31'd0, busy}, 32'd0);
    chk("s_sel_end", {30'd0, sel}, 32'd0);
    @(negedge clk);
    chk("s_valid_pulse", {31'd0, valid}, 32'd0);

    // Abort on channel 2
    a = 4'b0101;
    pulse_start();
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_sel", {30'd0, sel}, 32'd0);
    chk("ab_valid", {31'd0, valid}, 32'd0);
    chk("ab_sample", {28'd0, sample}, 32'h0000_000a);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) cnt++;
    end
    chk("ab_no_valid", cnt, 32'd0);

    // Restart, with a start pulse mid-scan that must be ignored
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_v(1'b0, 40, n);
    chk("rs_latency", n, 32'd13);
    chk("rs_sample", {28'd0, sample}, 32'h0000_0005);
    chk("rs_change", {31'd0, change}, 32'd1);

    // start + stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ss_busy_later", {31'd0, busy}, 32'd0);

    // stop on the channel-3 sample edge
    a = 4'b1111;
    pulse_start();
    repeat (15) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("st3_valid", {31'd0, valid}, 32'd0);
    chk("st3_busy", {31'd0, busy}, 32'd0);
    chk("st3_sample", {28'd0, sample}, 32'h0000_0005);
    @(negedge clk);
    chk("st3_valid_next", {31'd0, valid}, 32'd0);

    // Continuous mode
    mode = 1'b1;
    a = 4'b0110;
    pulse_start();
    wait_v(1'b0, 40, n);
    chk("c1_latency", n, 32'd16);
    chk("c1_sample", {28'd0, sample}, 32'h0000_0006);
    chk("c1_change", {31'd0, change}, 32'd1);
    a = 4'b1001;
    wait_v(1'b0, 40, n);
    chk("c2_period", n, 32'd16);
    chk("c2_sample", {28'd0, sample}, 32'h0000_0009);
    chk("c2_change", {31'd0, change}, 32'd1);
    chk("c2_busy", {31'd0, busy}, 32'd1);
    wait_v(1'b0, 40, n);
    chk("c3_period", n, 32'd16);
    chk("c3_sample", {28'd0, sample}, 32'h0000_0009);
    chk("c3_change", {31'd0, change}, 32'd0);
    mode = 1'b0;
    wait_v(1'b0, 40, n);
    chk("c4_period", n, 32'd16);
    chk("c4_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset between edges mid-scan
    mode = 1'b1;
    pulse_start();
    repeat (6) @(negedge clk);
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    chk("ar_sel_pre", {30'd0, sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", {30'd0, sel}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_sample", {28'd0, sample}, 32'd0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b0;
    @(negedge clk);

    // DWELL = 1
    a1 = 4'b1111;
    pulse_start1();
    chk("d1_busy", {31'd0, busy1}, 32'd1);
    wait_v(1'b1, 20, n);
    chk("d1_latency", n, 32'd4);
    chk("d1_sample", {28'd0, sample1}, 32'h0000_000f);
    chk("d1_change", {31'd0, change1}, 32'd1);
    chk("d1_busy_end", {31'd0, busy1}, 32'd0);
    mode1 = 1'b1;
    pulse_start1();
    @(negedge clk);
    chk("d1_sel_step", {30'd0, sel1}, 32'd1);
    wait_v(1'b1, 20, n);
    chk("d1c_latency", n, 32'd3);
    chk("d1c_change", {31'd0, change1}, 32'd0);
    wait_v(1'b1, 20, n);
    chk("d1c_period", n, 32'd4);
    chk("d1c_busy", {31'd0, busy1}, 32'd1);
    stop1 = 1'b1;
    @(negedge clk);
    stop1 = 1'b0;
    chk("d1_stop_busy", {31'd0, busy1}, 32'd0);
    chk("d1_stop_valid", {31'd0, valid1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
